// File: rtl/heli_game_ctrl_pkg.sv
// Shared definitions for the helicopter game sequencer: state encodings,
// screen/playfield geometry and the 8-bit LFSR step.
package heli_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_CRASH = 2'b10
  } game_state_t;

  localparam logic [9:0] H_ACTIVE   = 10'd640;
  localparam logic [9:0] V_ACTIVE   = 10'd480;
  localparam logic [9:0] HELI_X     = 10'd100;
  localparam logic [9:0] HELI_SIZE  = 10'd16;
  localparam logic [9:0] WALL_W     = 10'd32;
  localparam logic [9:0] GAP_H      = 10'd160;
  localparam logic [9:0] GAP_MIN    = 10'd64;
  localparam logic [9:0] WALL_SPEED = 10'd2;

  localparam logic signed [6:0] GRAV = 7'sd1;
  localparam logic signed [6:0] LIFT = 7'sd2;
  localparam logic signed [6:0] VMAX = 7'sd6;

  localparam logic [6:0] CRASH_FRAMES = 7'd120;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;

  localparam logic [9:0] HELI_Y0 = (V_ACTIVE >> 1) - (HELI_SIZE >> 1);
  localparam logic [9:0] GAP_Y0  = GAP_MIN + {2'b00, LFSR_SEED};

  // Fibonacci form, taps 8,6,5,4 (maximal length, so a nonzero seed never reaches zero)
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/heli_game_ctrl_lfsr.sv
// Free-running 8-bit LFSR used to pick the next wall gap position.
module heli_lfsr8
  import heli_game_ctrl_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= SEED;
    else       q <= lfsr_step(q);
  end

endmodule

// File: rtl/heli_game_ctrl.sv
// Helicopter game sequencer: per-frame physics, wall scroll, score and
// registered per-pixel object hits for the VGA colour path.
//
//   state  | meaning
//   IDLE   | positions parked at start values, waiting for a flap
//   PLAY   | physics and wall scroll advance once per frame tick
//   CRASH  | everything frozen; counts CRASH_FRAMES ticks then back to IDLE
module heli_game_ctrl
  import heli_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       btn_fly,
  output logic [1:0] state,
  output logic [9:0] heli_y,
  output logic [9:0] wall_x,
  output logic [9:0] gap_y,
  output logic [7:0] score,
  output logic       pix_heli,
  output logic       pix_wall,
  output logic       pix_crash
);

  game_state_t       st_q, st_d;
  logic [9:0]        heli_y_q, heli_y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [9:0]        wall_x_q, wall_x_d;
  logic [9:0]        gap_y_q, gap_y_d;
  logic [7:0]        score_q, score_d;
  logic [6:0]        crash_cnt_q, crash_cnt_d;

  logic              frame_tick;
  logic [7:0]        lfsr;

  logic signed [6:0]  vel_ext, vel_step;
  logic signed [10:0] y_new;
  logic [9:0]         y_clamp, wall_n, gap_n;
  logic               hit_top, hit_bot, wrap, overlap, in_gap, crash;

  logic [10:0]        px, py;
  logic               heli_hit, wall_hit;

  heli_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  // First blanking line, so positions only move while nothing is drawn
  assign frame_tick = (counter_x == 10'd0) && (counter_y == V_ACTIVE);

  always_comb begin
    vel_ext = {vel_q[5], vel_q};
    if (btn_fly) begin
      vel_step = vel_ext - LIFT;
      if (vel_step < -VMAX) vel_step = -VMAX;
    end else begin
      vel_step = vel_ext + GRAV;
      if (vel_step > VMAX) vel_step = VMAX;
    end

    y_new   = $signed({1'b0, heli_y_q}) + $signed({{4{vel_step[6]}}, vel_step});
    hit_top = y_new[10];
    hit_bot = !hit_top &&
              (({1'b0, y_new[9:0]} + {1'b0, HELI_SIZE}) > {1'b0, V_ACTIVE});
    y_clamp = hit_top ? 10'd0 : (hit_bot ? (V_ACTIVE - HELI_SIZE) : y_new[9:0]);

    wrap   = wall_x_q < WALL_SPEED;
    wall_n = wrap ? H_ACTIVE : (wall_x_q - WALL_SPEED);
    gap_n  = wrap ? (GAP_MIN + {2'b00, lfsr}) : gap_y_q;

    // Collision is judged against the post-tick wall and helicopter position
    overlap = ({1'b0, wall_n} < ({1'b0, HELI_X} + {1'b0, HELI_SIZE})) &&
              (({1'b0, wall_n} + {1'b0, WALL_W}) > {1'b0, HELI_X});
    in_gap  = (y_clamp >= gap_n) &&
              (({1'b0, y_clamp} + {1'b0, HELI_SIZE}) <= ({1'b0, gap_n} + {1'b0, GAP_H}));
    crash   = hit_top || hit_bot || (overlap && !in_gap);
  end

  always_comb begin
    st_d        = st_q;
    heli_y_d    = heli_y_q;
    vel_d       = vel_q;
    wall_x_d    = wall_x_q;
    gap_y_d     = gap_y_q;
    score_d     = score_q;
    crash_cnt_d = crash_cnt_q;

    if (frame_tick) begin
      unique case (st_q)
        ST_IDLE: begin
          if (btn_fly) begin
            st_d    = ST_PLAY;
            score_d = '0;
          end
        end
        ST_PLAY: begin
          vel_d    = vel_step[5:0];
          heli_y_d = y_clamp;
          if (crash) begin
            // Crash wins over a same-tick wrap: wall, gap and score stay put
            st_d        = ST_CRASH;
            crash_cnt_d = CRASH_FRAMES - 7'd1;
          end else begin
            wall_x_d = wall_n;
            gap_y_d  = gap_n;
            if (wrap && (score_q != 8'hFF)) score_d = score_q + 8'd1;
          end
        end
        ST_CRASH: begin
          if (crash_cnt_q == 7'd0) begin
            st_d     = ST_IDLE;
            heli_y_d = HELI_Y0;
            vel_d    = '0;
            wall_x_d = H_ACTIVE;
            gap_y_d  = GAP_Y0;
          end else begin
            crash_cnt_d = crash_cnt_q - 7'd1;
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      heli_y_q    <= HELI_Y0;
      vel_q       <= '0;
      wall_x_q    <= H_ACTIVE;
      gap_y_q     <= GAP_Y0;
      score_q     <= '0;
      crash_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      heli_y_q    <= heli_y_d;
      vel_q       <= vel_d;
      wall_x_q    <= wall_x_d;
      gap_y_q     <= gap_y_d;
      score_q     <= score_d;
      crash_cnt_q <= crash_cnt_d;
    end
  end

  always_comb begin
    px = {1'b0, counter_x};
    py = {1'b0, counter_y};
    heli_hit = (px >= {1'b0, HELI_X}) && (px < ({1'b0, HELI_X} + {1'b0, HELI_SIZE})) &&
               (py >= {1'b0, heli_y_q}) && (py < ({1'b0, heli_y_q} + {1'b0, HELI_SIZE}));
    wall_hit = (px >= {1'b0, wall_x_q}) && (px < ({1'b0, wall_x_q} + {1'b0, WALL_W})) &&
               (py < {1'b0, V_ACTIVE}) &&
               !((py >= {1'b0, gap_y_q}) && (py < ({1'b0, gap_y_q} + {1'b0, GAP_H})));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_heli  <= 1'b0;
      pix_wall  <= 1'b0;
      pix_crash <= 1'b0;
    end else begin
      pix_heli  <= heli_hit;
      pix_wall  <= wall_hit;
      pix_crash <= (st_q == ST_CRASH);
    end
  end

  assign state  = st_q;
  assign heli_y = heli_y_q;
  assign wall_x = wall_x_q;
  assign gap_y  = gap_y_q;
  assign score  = score_q;

endmodule
